// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory bus arbiter.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
        logic [1:0]        width;
    } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and DMA requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the master that lost the last grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_dma_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_e i_last,
`endif
    output logic   o_vld,
    output owner_e o_win
);

    always_comb begin
        o_vld = i_cpu_req | i_dma_req;
        o_win = OWN_CPU;
        if (i_cpu_req && i_dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            o_win = (i_last == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
            o_win = OWN_DMA;
`endif
        end else if (i_dma_req) begin
            o_win = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) single-beat sequencer for the shared memory bus.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [1:0]    cpu_width,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [1:0]    dma_width,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_width,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ok
);

    state_e        r_state;
    state_e        w_next;
    owner_e        r_owner;
    req_t          r_req;
    logic          r_cpu_gnt;
    logic          r_dma_gnt;
    logic          r_cpu_done;
    logic          r_dma_done;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;

    logic          w_vld;
    owner_e        w_win;
    logic          w_latch;
    logic          w_fin;
    logic          w_cap;
    req_t          w_cpu_fld;
    req_t          w_dma_fld;
    req_t          w_win_fld;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e        r_last;
`endif

    assign w_cpu_fld = '{
        we:    cpu_we,
        addr:  ARB_AW'(cpu_addr),
        wdata: ARB_DW'(cpu_wdata),
        width: cpu_width
    };
    assign w_dma_fld = '{
        we:    dma_we,
        addr:  ARB_AW'(dma_addr),
        wdata: ARB_DW'(dma_wdata),
        width: dma_width
    };
    assign w_win_fld = (w_win == OWN_DMA) ? w_dma_fld : w_cpu_fld;

    mem_arb_pick u_pick (
        .i_cpu_req (cpu_req),
        .i_dma_req (dma_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_last    (r_last),
`endif
        .o_vld     (w_vld),
        .o_win     (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_fin     = 1'b0;
        w_cap     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_vld) begin
                    w_next  = ACCESS;
                    w_latch = 1'b1;
                end
            end
            ACCESS: begin
                mem_read  = ~r_req.we;
                mem_write = r_req.we;
                if (mem_ok) begin
                    w_fin  = r_req.we;
                    w_next = r_req.we ? IDLE : DATA;
                end
            end
            DATA: begin
                // address and read stay up so the RAM output remains valid
                mem_read = 1'b1;
                if (mem_ok) begin
                    w_next = IDLE;
                    w_fin  = 1'b1;
                    w_cap  = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_CPU;
            r_req       <= '0;
            r_cpu_gnt   <= 1'b0;
            r_dma_gnt   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_owner <= w_win;
                r_req   <= w_win_fld;
            end
            r_cpu_gnt  <= w_latch && (w_win == OWN_CPU);
            r_dma_gnt  <= w_latch && (w_win == OWN_DMA);
            r_cpu_done <= w_fin && (r_owner == OWN_CPU);
            r_dma_done <= w_fin && (r_owner == OWN_DMA);
            if (w_cap && (r_owner == OWN_CPU)) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_cap && (r_owner == OWN_DMA)) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN_CPU;
        end else if (w_latch) begin
            r_last <= w_win;
        end
    end
`endif

    assign cpu_gnt   = r_cpu_gnt;
    assign dma_gnt   = r_dma_gnt;
    assign cpu_done  = r_cpu_done;
    assign dma_done  = r_dma_done;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_addr  = AW'(r_req.addr);
    assign mem_wdata = DW'(r_req.wdata);
    assign mem_width = r_req.width;

endmodule
